// File: rtl/arb_pkg.sv
// Shared definitions for the fair scheduler and its response router.
// Sizes, requester id type and the idle grant encoding.
package arb_pkg;

   localparam int unsigned LG_N     = 2;
   localparam int unsigned LG_DEPTH = 3;
   localparam int unsigned W        = 64;

   typedef logic [LG_N-1:0] req_id_t;

   localparam logic [LG_N:0] IDLE_ID = {(LG_N+1){1'b1}};

   // A grant carries a real requester only when the MSB of its encoding is clear.
   function automatic logic is_real_grant(input logic [LG_N:0] id);
      is_real_grant = ~id[LG_N];
   endfunction

endpackage

// File: rtl/arb_resp_router_if.sv
// Grant, downstream response and requester response buses of the router.
interface arb_resp_router_if
   import arb_pkg::*;
#(
   parameter int unsigned P_LG_N = LG_N,
   parameter int unsigned P_W    = W
);
   localparam int unsigned N = 1 << P_LG_N;

   logic              grant_valid;
   logic [P_LG_N:0]   grant_id;
   logic              grant_ready;
   logic              rsp_valid;
   logic [P_W-1:0]    rsp_data;
   logic              rsp_ready;
   logic [N-1:0]      out_valid;
   logic [P_W-1:0]    out_data;
   logic [N-1:0]      out_ready;

   modport master (
      output grant_valid, grant_id, rsp_valid, rsp_data, out_ready,
      input  grant_ready, rsp_ready, out_valid, out_data
   );

   modport slave (
      input  grant_valid, grant_id, rsp_valid, rsp_data, out_ready,
      output grant_ready, rsp_ready, out_valid, out_data
   );
endinterface

// File: rtl/arb_resp_router_tag_fifo.sv
// In-order store of granted requester ids; pop only sees entries written on an earlier edge.
module tag_fifo
   import arb_pkg::*;
#(
   parameter int unsigned P_LG_N     = LG_N,
   parameter int unsigned P_LG_DEPTH = LG_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [P_LG_N-1:0]     push_id_i,
   input  logic                  pop_i,
   output logic [P_LG_N-1:0]     pop_id_o,
   output logic [P_LG_DEPTH:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int unsigned            D        = 1 << P_LG_DEPTH;
   localparam logic [P_LG_DEPTH:0]    CNT_FULL = (P_LG_DEPTH+1)'(D);
   localparam logic [P_LG_DEPTH:0]    CNT_ONE  = (P_LG_DEPTH+1)'(1);
   localparam logic [P_LG_DEPTH-1:0]  PTR_ONE  = P_LG_DEPTH'(1);

   logic [P_LG_N-1:0]     mem_q [D];
   logic [P_LG_DEPTH-1:0] wr_q, rd_q;
   logic [P_LG_DEPTH:0]   cnt_q;
   logic                  push_s, pop_s;

   assign full_o   = (cnt_q == CNT_FULL);
   assign empty_o  = (cnt_q == {(P_LG_DEPTH+1){1'b0}});
   assign push_s   = push_i & ~full_o;
   assign pop_s    = pop_i & ~empty_o;
   assign pop_id_o = mem_q[rd_q];
   assign count_o  = cnt_q;

   // Pointers wrap naturally; occupancy comes only from the counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= {P_LG_DEPTH{1'b0}};
         rd_q  <= {P_LG_DEPTH{1'b0}};
         cnt_q <= {(P_LG_DEPTH+1){1'b0}};
      end else begin
         if (push_s) wr_q <= wr_q + PTR_ONE;
         if (pop_s)  rd_q <= rd_q + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   cnt_q <= cnt_q + CNT_ONE;
            2'b01:   cnt_q <= cnt_q - CNT_ONE;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_q] <= push_id_i;
   end

endmodule

// File: rtl/arb_resp_router.sv
// Steers in-order downstream responses back to the requester recorded for each grant,
// through a one-entry output register that drains under per-requester backpressure.
module arb_resp_router
   import arb_pkg::*;
#(
   parameter int unsigned P_LG_N     = LG_N,
   parameter int unsigned P_LG_DEPTH = LG_DEPTH,
   parameter int unsigned P_W        = W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   arb_resp_router_if.slave     bus,
   output logic [P_LG_DEPTH:0]  outstanding,
   output logic                 err_overflow,
   output logic                 err_orphan
);
   localparam int unsigned N = 1 << P_LG_N;

   logic                 hold_v_q, hold_v_d;
   logic [P_LG_N-1:0]    hold_id_q, hold_id_d;
   logic [P_W-1:0]       hold_data_q, hold_data_d;
   logic                 ovf_q, ovf_d, orph_q, orph_d;
   logic                 push_s, pop_s, drain_s, full_s, empty_s, real_grant_s;
   logic [P_LG_N-1:0]    pop_id_s;

   tag_fifo #(.P_LG_N(P_LG_N), .P_LG_DEPTH(P_LG_DEPTH)) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push_s),
      .push_id_i (bus.grant_id[P_LG_N-1:0]),
      .pop_i     (pop_s),
      .pop_id_o  (pop_id_s),
      .count_o   (outstanding),
      .full_o    (full_s),
      .empty_o   (empty_s)
   );

   assign real_grant_s    = bus.grant_valid & is_real_grant(bus.grant_id);
   assign bus.grant_ready = ~full_s;
   assign push_s          = real_grant_s & ~full_s;
   assign drain_s         = hold_v_q & bus.out_ready[hold_id_q];
   assign bus.rsp_ready   = ~empty_s & (~hold_v_q | drain_s);
   assign pop_s           = bus.rsp_valid & bus.rsp_ready;
   assign bus.out_valid   = hold_v_q ? (N'(1) << hold_id_q) : {N{1'b0}};
   assign bus.out_data    = hold_data_q;
   assign err_overflow    = ovf_q;
   assign err_orphan      = orph_q;

   // A pop refills the output register even while it drains, giving one response per cycle.
   always_comb begin
      hold_v_d    = hold_v_q;
      hold_id_d   = hold_id_q;
      hold_data_d = hold_data_q;
      if (pop_s) begin
         hold_v_d    = 1'b1;
         hold_id_d   = pop_id_s;
         hold_data_d = bus.rsp_data;
      end else if (drain_s) begin
         hold_v_d    = 1'b0;
      end else begin
         hold_v_d    = hold_v_q;
      end
      ovf_d  = ovf_q | (real_grant_s & full_s);
      orph_d = orph_q | (bus.rsp_valid & empty_s);
   end

   // Output register and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_v_q    <= 1'b0;
         hold_id_q   <= {P_LG_N{1'b0}};
         hold_data_q <= {P_W{1'b0}};
         ovf_q       <= 1'b0;
         orph_q      <= 1'b0;
      end else begin
         hold_v_q    <= hold_v_d;
         hold_id_q   <= hold_id_d;
         hold_data_q <= hold_data_d;
         ovf_q       <= ovf_d;
         orph_q      <= orph_d;
      end
   end

endmodule
